// File: rtl/irq_pending_ctrl_if.sv
// irq_pending_ctrl_if
//   Bundles the request/acknowledge bus of irq_pending_ctrl.
//   master : the request source / interrupt consumer (drives req, mask, ack, clr_overrun)
//   slave  : the pending controller (drives irq_valid, irq_id, pending, overrun)
//   req[3:0]        raw request lines, bit 3 highest priority
//   mask[3:0]       1 = channel masked (kept pending, not presented)
//   ack             consumer acknowledge of the presented id
//   clr_overrun     clears all overrun flags
//   irq_valid       an id is being presented
//   irq_id[1:0]     encoded presented channel
//   pending[3:0]    pending vector
//   overrun[3:0]    sticky lost-edge flags
interface irq_pending_ctrl_if;
  logic [3:0] req;
  logic [3:0] mask;
  logic       ack;
  logic       clr_overrun;
  logic       irq_valid;
  logic [1:0] irq_id;
  logic [3:0] pending;
  logic [3:0] overrun;

  modport master (
    output req, mask, ack, clr_overrun,
    input  irq_valid, irq_id, pending, overrun
  );

  modport slave (
    input  req, mask, ack, clr_overrun,
    output irq_valid, irq_id, pending, overrun
  );
endinterface

// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl
//   Captures four request lines into pending bits (rising-edge sticky when
//   EDGE=1, registered level when EDGE=0), flags lost edges as overruns and
//   presents the highest-priority unmasked pending channel to a consumer,
//   holding the presented id stable until it is acknowledged.
//   clk  : single clock, all state on rising edge
//   rst  : synchronous active-high reset, priority over all inputs
//   bus  : irq_pending_ctrl_if.slave (req/mask/ack/clr_overrun in,
//          irq_valid/irq_id/pending/overrun out, all outputs registered)
module irq_pending_ctrl #(
  parameter bit EDGE = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  irq_pending_ctrl_if.slave  bus
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [3:0] r_req_q;
  logic [3:0] r_pending;
  logic [3:0] r_overrun;
  logic [1:0] r_irq_id;

  logic [3:0] w_edge;
  logic [3:0] w_elig;
  logic [3:0] w_ack_clr;
  logic [3:0] w_ovr_set;
  logic [1:0] w_winner;
  logic       w_irq_valid;
  logic       w_load_id;
  logic       w_ack_take;

  assign w_edge = bus.req & ~r_req_q;
  assign w_elig = r_pending & ~bus.mask;

  // Fixed priority: iterate upward so the highest set bit is the last writer.
  always_comb begin
    w_winner = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (w_elig[i]) w_winner = 2'(i);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_elig != '0) w_state_nxt = PRESENT;
      PRESENT: if (bus.ack)      w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_irq_valid = (r_state == PRESENT);
    w_load_id   = (r_state == IDLE) && (w_elig != '0);
    w_ack_take  = (r_state == PRESENT) && bus.ack;
    w_ack_clr   = '0;
    if (w_ack_take) w_ack_clr[r_irq_id] = 1'b1;
  end

  // Overrun only when the bit stays pending through this edge, i.e. it is not
  // being acknowledged in the same cycle the new edge arrives.
  assign w_ovr_set = w_edge & r_pending & ~w_ack_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_q   <= '0;
      r_pending <= '0;
      r_overrun <= '0;
      r_irq_id  <= '0;
    end else begin
      r_req_q <= bus.req;
      if (EDGE) begin
        // Set has priority over the acknowledge clear.
        r_pending <= (r_pending & ~w_ack_clr) | w_edge;
        // A new overrun survives a simultaneous clear request.
        r_overrun <= (r_overrun & ~{4{bus.clr_overrun}}) | w_ovr_set;
      end else begin
        r_pending <= bus.req;
        r_overrun <= '0;
      end
      if (w_load_id) r_irq_id <= w_winner;
    end
  end

  assign bus.irq_valid = w_irq_valid;
  assign bus.irq_id    = r_irq_id;
  assign bus.pending   = r_pending;
  assign bus.overrun   = r_overrun;

endmodule

// File: doc/irq_pending_ctrl.md
IRQ_PENDING_CTRL -- requirements
Module: irq_pending_ctrl

Interface
REQ-001 Parameter: EDGE, default 1, 1 = rising-edge capture into sticky pending bits, 0 = level mode (pending follows registered req).
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: req  input  4  raw request lines, bit 3 highest priority.
REQ-005 Port: mask  input  4  1 = channel masked (stays pending, not presented).
REQ-006 Port: ack  input  1  consumer acknowledge of the presented id.
REQ-007 Port: clr_overrun  input  1  clears all overrun bits.
REQ-008 Port: irq_valid  output  1  registered, an id is being presented.
REQ-009 Port: irq_id  output  2  registered, encoded channel number (11 = ch3 ... 00 = ch0).
REQ-010 Port: pending  output  4  registered pending vector.
REQ-011 Port: overrun  output  4  registered sticky flags, a request edge was lost on that channel.

Function
REQ-012 The block SHALL register req into req_q each cycle; edge on bit i = req[i] & ~req_q[i].
REQ-013 EDGE=1: pending[i] SHALL set on an edge and clear only at an ack clock edge while irq_valid=1 and irq_id=i.
REQ-014 EDGE=1: a simultaneous edge and ack-clear on the same bit SHALL leave pending[i]=1 (set wins) and SHALL NOT set overrun[i].
REQ-015 EDGE=1: an edge on bit i while pending[i]=1 and no clear that cycle SHALL set overrun[i]; overrun[i] holds until clr_overrun or rst.
REQ-016 clr_overrun and a new overrun set in the same cycle SHALL leave that bit set.
REQ-017 EDGE=0: pending SHALL equal req_q; ack clears nothing; overrun stays 0.
REQ-018 Eligible vector elig = pending & ~mask; selection is fixed priority, highest set bit wins (e.g. elig=1001 -> id 11, elig=0110 -> id 10).
REQ-019 FSM has two states: IDLE (irq_valid=0) and PRESENT (irq_valid=1).
REQ-020 IDLE -> PRESENT at a clock edge where elig != 0; irq_id SHALL load the encoded winner at that edge.
REQ-021 In PRESENT, irq_id SHALL remain stable regardless of later req/mask/pending changes until acknowledged.
REQ-022 PRESENT -> IDLE at a clock edge with ack=1; irq_valid SHALL be 0 for at least one cycle before the next presentation.
REQ-023 ack while IDLE SHALL be ignored.
REQ-024 Latency (EDGE=1, unmasked, IDLE): req rises before edge E0, pending set after E0, irq_valid=1 after E1 (2 cycles).
REQ-025 Masking a channel while it is presented SHALL NOT withdraw it; its pending bit is still cleared on ack.
REQ-026 irq_id SHALL hold its last value while IDLE.

Reset
REQ-027 While rst=1 at a clock edge: req_q=0, pending=0, overrun=0, irq_valid=0, irq_id=00, state=IDLE; rst has priority over all other inputs.
REQ-028 Because req_q resets to 0, a req bit held high through reset SHALL be captured as one edge on the first cycle after reset release.
REQ-029 rst asserted while PRESENT SHALL drop irq_valid and discard all pending requests with no ack required.

Verification
REQ-030 req=0001 pulse, mask=0 -> pending=0001, irq_valid=1, irq_id=00 two cycles after req rise; ack -> pending=0000, irq_valid=0 next cycle.
REQ-031 req=1001 simultaneous edges -> irq_id=11 first; after ack, bubble cycle, then irq_id=00; after second ack pending=0000.
REQ-032 ch1 pending and presented, second req[1] edge before ack -> overrun=0010; clr_overrun pulse -> overrun=0000.
REQ-033 ch2 presented, mask=0100 and req[3] edge during PRESENT -> irq_id stays 10 until ack, then 11 presented.
REQ-034 req[0] held high across rst deassertion -> exactly one presentation of id 00, no overrun.
REQ-035 rst pulse while PRESENT with pending=0110 -> all outputs 0 next cycle, no presentation until a new edge.
